// File: rtl/counter_overflow_monitor.sv
// Wrap / overflow-rise monitor with a req/ack interrupt and hold-off window.
// Optional sticky threshold flag: define COUNTER_MONITOR_THRESH_EN.
module counter_overflow_monitor #(
  parameter int             CNT_W   = 4,
  parameter int             EVT_W   = 8,
  parameter int             HOLDOFF = 2,
  parameter logic [EVT_W-1:0] THRESH = 8'd10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] counter_in,
  input  logic             overflow_in,
  input  logic             ack,
  input  logic             clear_events,
  output logic             irq,
  output logic [1:0]       irq_cause,
  output logic [EVT_W-1:0] event_count,
  output logic             missed,
  output logic             thresh_hit
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_HOLD
  } state_t;

  localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);

  logic [CNT_W-1:0] prev_count_q;
  logic             prev_ovf_q;
  logic             ovf_rise;
  logic             wrap;
  logic             evt;
  logic             inc;

  logic [EVT_W-1:0] event_count_q;
  logic [EVT_W-1:0] event_count_d;
  logic             missed_q;
  logic             missed_d;

  state_t           state_q;
  logic             irq_q;
  logic [1:0]       cause_q;
  logic [3:0]       hold_q;

  assign ovf_rise = overflow_in & ~prev_ovf_q;
  assign wrap     = (prev_count_q == {CNT_W{1'b1}})
                  && (counter_in == '0);
  assign evt      = ovf_rise | wrap;
  assign inc      = wrap && (event_count_q != {EVT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_count_q <= '0;
      prev_ovf_q   <= 1'b0;
    end else begin
      prev_count_q <= counter_in;
      prev_ovf_q   <= overflow_in;
    end
  end

  always_comb begin
    event_count_d = event_count_q;
    missed_d      = missed_q;
    if (clear_events) begin
      event_count_d = '0;
      missed_d      = 1'b0;
    end else begin
      if (inc) event_count_d = event_count_q + EVT_W'(1);
      if (evt && state_q != S_IDLE) missed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      event_count_q <= '0;
      missed_q      <= 1'b0;
    end else begin
      event_count_q <= event_count_d;
      missed_q      <= missed_d;
    end
  end

  // Events outside IDLE are dropped here; only missed records them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      irq_q   <= 1'b0;
      cause_q <= 2'b00;
      hold_q  <= 4'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (evt) begin
            irq_q   <= 1'b1;
            cause_q <= {wrap, ovf_rise};
            state_q <= S_PEND;
          end
        end
        S_PEND: begin
          if (ack) begin
            irq_q   <= 1'b0;
            hold_q  <= HOLD_INIT;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (hold_q <= 4'd1) state_q <= S_IDLE;
          else hold_q <= hold_q - 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef COUNTER_MONITOR_THRESH_EN
  logic thresh_q;
  logic thresh_d;

  always_comb begin
    thresh_d = thresh_q;
    if (clear_events) thresh_d = 1'b0;
    else if (inc && event_count_d == THRESH) thresh_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) thresh_q <= 1'b0;
    else thresh_q <= thresh_d;
  end

  assign thresh_hit = thresh_q;
`else
  assign thresh_hit = 1'b0;
`endif

  assign irq         = irq_q;
  assign irq_cause   = cause_q;
  assign event_count = event_count_q;
  assign missed      = missed_q;

endmodule

// File: doc/counter_overflow_monitor.md
Name: counter_overflow_monitor

Overview:
- Downstream consumer of the 4-bit enable counter's `counter_out`/`overflow_out` pair.
- Detects counter wrap (all-ones -> 0) and rising edges of the sticky overflow flag.
- Raises a single-source interrupt with a req/ack handshake and a hold-off window.
- Keeps a saturating wrap-event count for software/status logic.

Parameters:
- CNT_W, 4, width of monitored counter value.
- EVT_W, 8, width of saturating wrap-event counter.
- HOLDOFF, 2, cycles irq stays low after ack before a new irq may assert (legal range 1..15).
- THRESH, 8'd10, wrap-count threshold used only when the optional feature is compiled in.

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- counter_in  input  CNT_W  counter value from upstream counter.
- overflow_in  input  1  sticky overflow flag from upstream counter.
- ack  input  1  interrupt acknowledge, sampled on posedge.
- clear_events  input  1  synchronous clear of event_count, missed and thresh_hit.
- irq  output  1  interrupt request, level.
- irq_cause  output  2  bit0 = overflow rise, bit1 = wrap; valid while irq=1.
- event_count  output  EVT_W  saturating count of wrap events.
- missed  output  1  sticky: an event occurred while not in IDLE.
- thresh_hit  output  1  sticky threshold flag (optional feature).

Behaviour:
- Reset (synchronous, reset=1 at posedge) sets the following:
  - prev_count=0 and prev_ovf=0.
  - irq=0, irq_cause=0, event_count=0, missed=0, thresh_hit=0.
  - State=IDLE.
  - Reset overrides all other inputs, including mid-handshake.
- Edge detect:
  - ovf_rise = overflow_in & ~prev_ovf.
  - wrap = (prev_count == all-ones) & (counter_in == 0).
  - event = ovf_rise | wrap.
  - prev_* registered every cycle.
  - counter_in==0 directly after reset is not a wrap, because prev_count=0.
- event_count:
  - +1 on each cycle with wrap=1.
  - Saturates at 2^EVT_W-1 with no rollover.
  - clear_events has priority over increment in the same cycle.
- FSM states:
  - IDLE: on event, next cycle irq=1 and irq_cause={wrap,ovf_rise} latched, go to PENDING. ack ignored.
  - PENDING: irq held at 1 and irq_cause frozen. On ack, irq=0 next cycle, load holdoff counter with HOLDOFF, go to HOLDOFF.
  - HOLDOFF: holdoff counter decrements each cycle; at 1, go to IDLE. irq stays 0 for exactly HOLDOFF cycles after deassertion.
  - Transitions out of IDLE are evaluated in the cycle after the new state is entered.
- Events in PENDING or HOLDOFF (including the ack cycle):
  - Set missed=1.
  - Are not queued and never produce a later irq.
  - Still increment event_count if wrap.
- Simultaneous wrap and ovf_rise: one irq with irq_cause=2'b11.
- Latency: event-cycle inputs -> irq high 1 cycle later. ack -> irq low 1 cycle later.
- clear_events: clears event_count, missed and thresh_hit. Does not affect the FSM or irq.

Optional Feature:
- COUNTER_MONITOR_THRESH_EN defined:
  - thresh_hit is set in the cycle event_count transitions to THRESH.
  - thresh_hit is sticky until clear_events or reset.
  - If clear_events and the reaching increment coincide, the clear wins.
- Not defined:
  - thresh_hit is tied to 0.
  - No comparator logic is present.
  - The port remains.

Test Plan:
- Reset then counter_in sweeps 0..15 -> 0 with overflow_in rising at the same cycle as the 0 -> irq=1 one cycle later, irq_cause=2'b11, event_count=1.
- Hold irq 5 cycles without ack, then pulse ack -> irq stays 1 until the ack edge, drops next cycle, stays 0 for exactly 2 cycles (HOLDOFF=2). A wrap injected during hold-off sets missed=1, gives no new irq, and gives event_count=2.
- 260 wraps with acks serviced, EVT_W=8 -> event_count saturates at 255. clear_events in the same cycle as a wrap -> event_count=0.
- overflow_in held high for 20 cycles -> exactly one ovf_rise irq (irq_cause=2'b01). A counter jump 15 -> 3 is not a wrap.
- Assert reset while in PENDING -> next cycle irq=0, state IDLE, all counters 0. counter_in=0 in the following cycle produces no irq.
- With COUNTER_MONITOR_THRESH_EN and THRESH=10: 10 wraps -> thresh_hit=1 on the 10th, stays 1 through further wraps, cleared by clear_events. Without the macro -> thresh_hit stays 0.
